// File: rtl/jtkcpu_useq.sv
// Microcode sequencer for the jtkcpu core.
// Holds the microcode row address and decodes the sequencing op (sop) of the
// current row. It also keeps a small return stack for CALL/RET and for the
// indexed-source detour taken by NI.
// Stack overflow, stack underflow and the HALT ops stop the sequencer until rst.
//
// uword layout, LSB first: sop[2:0] | csel[CSW-1:0] | tgt[RW-1:0] | ctrl[CTRL_DW-1:0]
module jtkcpu_useq #(
  parameter int UCODE_AW   = 10,
  parameter int ROUTINE_AW = 4,
  parameter int OPCAT_AW   = 5,
  parameter int CTRL_DW    = 24,
  parameter int CSW        = 3,
  parameter int STK_DEPTH  = 2,
  parameter int IDX_RT     = 32,
  localparam int RW        = UCODE_AW - ROUTINE_AW,
  localparam int UW        = CTRL_DW + RW + CSW + 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cen,
  input  logic [OPCAT_AW-1:0]   opcat,
  input  logic                  idx_src,
  input  logic [(1<<CSW)-1:0]   cond,
  output logic [UCODE_AW-1:0]   uaddr,
  input  logic [UW-1:0]         uword,
  output logic [CTRL_DW-1:0]    ctrl,
  output logic                  ni,
  output logic                  halted,
  output logic                  stk_err
);

  localparam int DW = $clog2(STK_DEPTH + 1);

  typedef enum logic [2:0] {
    SOP_NEXT = 3'd0,
    SOP_NI   = 3'd1,
    SOP_WAIT = 3'd2,
    SOP_JMPC = 3'd3,
    SOP_CALL = 3'd4,
    SOP_RET  = 3'd5,
    SOP_HALT = 3'd6,
    SOP_RSVD = 3'd7
  } sop_e;

  logic [UCODE_AW-1:0] uaddr_q, uaddr_d;
  logic                halted_q, halted_d;
  logic                stk_err_q, stk_err_d;
  logic [DW-1:0]       depth_q, depth_d;
  logic [UCODE_AW-1:0] stk_q [STK_DEPTH];
  logic [UCODE_AW-1:0] stk_d [STK_DEPTH];

  sop_e                sop;
  logic [CSW-1:0]      csel;
  logic [RW-1:0]       tgt;
  logic [RW-1:0]       opcat_idx;
  logic                cond_hit;
  logic                en;
  logic                stk_full;
  logic                stk_empty;
  logic [UCODE_AW-1:0] seq_addr;
  logic [UCODE_AW-1:0] top_addr;
  logic                push;
  logic [UCODE_AW-1:0] push_val;
  logic                ni_o;

  function automatic logic [UCODE_AW-1:0] base(input logic [RW-1:0] idx);
    return {idx, {ROUTINE_AW{1'b0}}};
  endfunction

  assign sop       = sop_e'(uword[2:0]);
  assign csel      = uword[3 +: CSW];
  assign tgt       = uword[3+CSW +: RW];
  assign opcat_idx = RW'(opcat);
  assign cond_hit  = cond[csel];
  assign en        = cen && !halted_q;
  assign stk_full  = (depth_q == DW'(STK_DEPTH));
  assign stk_empty = (depth_q == '0);
  assign seq_addr  = uaddr_q + UCODE_AW'(1);

  // Select the top-of-stack entry (the one just below the depth pointer).
  always_comb begin
    top_addr = '0;
    for (int i = 0; i < STK_DEPTH; i++) begin
      if (DW'(i + 1) == depth_q) top_addr = stk_q[i];
    end
  end

  // Decode sop and compute the next address, stack, and halt state.
  // A stack fault freezes uaddr, and the push that caused it is dropped.
  always_comb begin
    uaddr_d   = uaddr_q;
    halted_d  = halted_q;
    stk_err_d = stk_err_q;
    depth_d   = depth_q;
    stk_d     = stk_q;
    push      = 1'b0;
    push_val  = '0;
    ni_o      = 1'b0;
    if (en) begin
      case (sop)
        SOP_NEXT: uaddr_d = seq_addr;
        SOP_NI: begin
          if (idx_src) begin
            if (stk_full) begin
              halted_d  = 1'b1;
              stk_err_d = 1'b1;
            end else begin
              ni_o     = 1'b1;
              push     = 1'b1;
              push_val = base(opcat_idx);
              uaddr_d  = base(RW'(IDX_RT));
            end
          end else begin
            ni_o    = 1'b1;
            uaddr_d = base(opcat_idx);
          end
        end
        SOP_WAIT: if (!cond_hit) uaddr_d = seq_addr;
        SOP_JMPC: uaddr_d = cond_hit ? base(tgt) : seq_addr;
        SOP_CALL: begin
          if (stk_full) begin
            halted_d  = 1'b1;
            stk_err_d = 1'b1;
          end else begin
            push     = 1'b1;
            push_val = seq_addr;
            uaddr_d  = base(tgt);
          end
        end
        SOP_RET: begin
          if (stk_empty) begin
            halted_d  = 1'b1;
            stk_err_d = 1'b1;
          end else begin
            uaddr_d = top_addr;
            depth_d = depth_q - DW'(1);
          end
        end
        default: halted_d = 1'b1;
      endcase
    end
    if (push) begin
      for (int i = 0; i < STK_DEPTH; i++) begin
        if (DW'(i) == depth_q) stk_d[i] = push_val;
      end
      depth_d = depth_q + DW'(1);
    end
  end

  // Sequencer state register. rst overrides cen, and any pending push or pop is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      uaddr_q   <= '0;
      halted_q  <= 1'b0;
      stk_err_q <= 1'b0;
      depth_q   <= '0;
    end else begin
      uaddr_q   <= uaddr_d;
      halted_q  <= halted_d;
      stk_err_q <= stk_err_d;
      depth_q   <= depth_d;
    end
  end

  // Stack contents need no reset; the depth counter qualifies them.
  always_ff @(posedge clk) begin
    stk_q <= stk_d;
  end

  assign uaddr   = uaddr_q;
  assign halted  = halted_q;
  assign stk_err = stk_err_q;
  assign ni      = ni_o;
  assign ctrl    = halted_q ? '0 : uword[UW-1 -: CTRL_DW];

endmodule

// File: tb/tb_jtkcpu_useq.sv
// Scoreboarded bench for jtkcpu_useq: stimulus pushes expected values per
// cycle, a negedge monitor pops and compares them against the DUT.
module tb_jtkcpu_useq;

  localparam int NEXT = 0, NI = 1, WAIT = 2, JMPC = 3, CALL = 4, RET = 5, HALT = 6, RSVD = 7;

  logic        clk = 1'b0;
  logic        rst, cen, idx_src;
  logic [4:0]  opcat;
  logic [7:0]  cond;
  logic [9:0]  uaddr;
  logic [35:0] uword;
  logic [23:0] ctrl;
  logic        ni, halted, stk_err;
  logic [35:0] rom [1024];

  assign uword = rom[uaddr];

  always #5 clk = ~clk;

  jtkcpu_useq dut (
    .clk(clk), .rst(rst), .cen(cen), .opcat(opcat), .idx_src(idx_src),
    .cond(cond), .uaddr(uaddr), .uword(uword), .ctrl(ctrl), .ni(ni),
    .halted(halted), .stk_err(stk_err)
  );

  typedef enum int {S_UA, S_HALT, S_SERR, S_NI, S_CTRL, S_DEPTH} sig_e;
  typedef struct {
    string       name;
    sig_e        sig;
    logic [31:0] exp;
  } chk_t;

  chk_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [23:0] ctrl_of(input int a);
    logic [9:0] a10;
    a10 = 10'(a);
    return {4'hA, 10'h000, a10};
  endfunction

  function automatic logic [35:0] mk(input int sop, input int csel, input int tgt, input int a);
    return {ctrl_of(a), 6'(tgt), 3'(csel), 3'(sop)};
  endfunction

  task automatic fill_rom();
    for (int i = 0; i < 1024; i++) rom[i] = mk(NEXT, 0, 0, i);
  endtask

  task automatic put(input int a, input int sop, input int csel, input int tgt);
    rom[a] = mk(sop, csel, tgt, a);
  endtask

  task automatic ex(input string n, input sig_e s, input logic [31:0] v);
    chk_t c;
    c.name = n;
    c.sig  = s;
    c.exp  = v;
    sbq.push_back(c);
  endtask

  task automatic ex_state(input string n, input int ua, input int h, input int se, input int d);
    ex({n, ".uaddr"}, S_UA, 32'(ua));
    ex({n, ".halted"}, S_HALT, 32'(h));
    ex({n, ".stk_err"}, S_SERR, 32'(se));
    ex({n, ".depth"}, S_DEPTH, 32'(d));
    ex({n, ".ctrl"}, S_CTRL, (h != 0) ? 32'd0 : 32'(ctrl_of(ua)));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cen = 1'b1; idx_src = 1'b0; cond = '0; opcat = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Monitor: compare every expectation queued for the current cycle.
  always @(negedge clk) begin
    chk_t        c;
    logic [31:0] act;
    while (sbq.size() > 0) begin
      c = sbq.pop_front();
      case (c.sig)
        S_UA:    act = 32'(uaddr);
        S_HALT:  act = 32'(halted);
        S_SERR:  act = 32'(stk_err);
        S_NI:    act = 32'(ni);
        S_CTRL:  act = 32'(ctrl);
        default: act = 32'(dut.depth_q);
      endcase
      n_cmp++;
      if (act !== c.exp) begin
        n_bad++;
        $display("FAIL %s: got %0h expected %0h", c.name, act, c.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // NI dispatch, cen gating of ni
    fill_rom(); put(0, NI, 0, 0);
    do_reset();
    cen = 1'b0; opcat = 5'd5;
    ex_state("rst", 0, 0, 0, 0); ex("ni_cen0", S_NI, 0);
    step();
    ex_state("cen0_hold", 0, 0, 0, 0);
    cen = 1'b1;
    ex("ni_strobe", S_NI, 1);
    step();
    ex_state("ni_dispatch", 'h050, 0, 0, 0); ex("ni_off", S_NI, 0);
    step();

    // NI with indexed source, then RET back to the opcode routine
    fill_rom(); put(0, NI, 0, 0); put('h200, RET, 0, 0);
    do_reset();
    opcat = 5'd3; idx_src = 1'b1;
    ex("ni_idx", S_NI, 1);
    step();
    idx_src = 1'b0;
    ex_state("idx_rt", 'h200, 0, 0, 1);
    step();
    ex_state("ret_idx", 'h030, 0, 0, 0);
    step();

    // WAIT on cond[1]
    fill_rom(); put(0, WAIT, 1, 0);
    do_reset();
    cond = 8'h02;
    for (int k = 0; k < 4; k++) begin
      ex_state("wait_hold", 0, 0, 0, 0);
      step();
    end
    cond = 8'h01;
    ex_state("wait_last", 0, 0, 0, 0);
    step();
    ex_state("wait_adv", 1, 0, 0, 0);
    step();

    // Nested CALLs overflow a 2-deep stack
    fill_rom(); put(0, CALL, 0, 1); put('h10, CALL, 0, 2); put('h20, CALL, 0, 3);
    do_reset();
    ex_state("call0", 0, 0, 0, 0);
    step();
    ex_state("call1", 'h10, 0, 0, 1);
    step();
    ex_state("call2", 'h20, 0, 0, 2);
    step();
    ex_state("call_ovf", 'h20, 1, 1, 2); ex("ovf_ni", S_NI, 0);
    step();
    ex_state("ovf_frozen", 'h20, 1, 1, 2);
    step();

    // LIFO unwind, then RET on empty stack
    fill_rom(); put(0, CALL, 0, 1); put('h10, CALL, 0, 2);
    put('h20, RET, 0, 0); put('h11, RET, 0, 0); put('h01, RET, 0, 0);
    do_reset();
    step();
    ex_state("lifo_c1", 'h10, 0, 0, 1);
    step();
    ex_state("lifo_c2", 'h20, 0, 0, 2);
    step();
    ex_state("lifo_r1", 'h11, 0, 0, 1);
    step();
    ex_state("lifo_r2", 'h01, 0, 0, 0);
    step();
    ex_state("ret_udf", 'h01, 1, 1, 0);
    step();

    // JMPC taken under cen low, address wrap, JMPC not taken
    fill_rom(); put(0, JMPC, 2, 63);
    do_reset();
    cond = 8'h04; cen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ex_state("jmpc_cen0", 0, 0, 0, 0);
      step();
    end
    cen = 1'b1;
    ex_state("jmpc_en", 0, 0, 0, 0);
    step();
    ex_state("jmpc_taken", 'h3F0, 0, 0, 0);
    cond = 8'hFB;
    repeat (15) step();
    ex_state("top_row", 'h3FF, 0, 0, 0);
    step();
    ex_state("wrap", 'h000, 0, 0, 0);
    step();
    ex_state("jmpc_nt", 'h001, 0, 0, 0);
    step();

    // HALT with a non-empty stack, then rst with cen low
    fill_rom(); put(0, CALL, 0, 1); put('h10, HALT, 0, 0);
    do_reset();
    step();
    ex_state("pre_halt", 'h10, 0, 0, 1);
    step();
    ex_state("halt", 'h10, 1, 0, 1);
    step();
    ex_state("halt_hold", 'h10, 1, 0, 1);
    rst = 1'b1; cen = 1'b0;
    step();
    ex_state("rst_halt", 0, 0, 0, 0);
    rst = 1'b0; cen = 1'b1;
    step();
    ex_state("post_rst", 'h10, 0, 0, 1);
    step();

    // Reserved sop behaves as HALT
    fill_rom(); put(0, RSVD, 0, 0);
    do_reset();
    step();
    ex_state("rsvd", 0, 1, 0, 0);
    step();

    if (sbq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
